fifo_multi_port: RTL and testbench

//  Circular-buffer FIFO that accepts 0..PUSH_PORTS entries and releases 0..POP_PORTS entries per cycle.

---
 rtl/fifo_multi_port.sv | 120 ++++++++++++
 tb/tb_fifo_multi_port.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_multi_port.sv
// Multi-port circular FIFO: 0..PUSH_PORTS entries in, 0..POP_PORTS entries out per cycle,
// all-or-nothing acknowledges, occupancy/free counts and almost-full/empty flags.

module fifo_multi_port_wrap #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic [PTR_W-1:0] base,
  input  logic [PTR_W:0]   ofs,
  output logic [PTR_W-1:0] idx
);
  localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);
  logic [PTR_W:0] sum;

  // base < DEPTH and ofs <= DEPTH, so one conditional subtract wraps any depth
  assign sum = {1'b0, base} + ofs;
  assign idx = (sum >= DEPTH_P) ? PTR_W'(sum - DEPTH_P) : sum[PTR_W-1:0];
endmodule

module fifo_multi_port #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PUSH_PORTS = 2,
  parameter int POP_PORTS  = 2,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int PSH_W = $clog2(PUSH_PORTS+1),
  localparam int POP_W = $clog2(POP_PORTS+1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [PSH_W-1:0]                      push_cnt_i,
  input  logic [PUSH_PORTS-1:0][DATA_WIDTH-1:0] data_i,
  output logic                                  push_ack_o,
  input  logic [POP_W-1:0]                      pop_cnt_i,
  output logic [POP_PORTS-1:0][DATA_WIDTH-1:0]  data_o,
  output logic [POP_PORTS-1:0]                  valid_o,
  output logic                                  pop_ack_o,
  output logic [CNT_W-1:0]                      usage_o,
  output logic [CNT_W-1:0]                      free_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic                                  almost_full_o,
  output logic                                  almost_empty_o
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0]                mem [DEPTH];
  logic [PTR_W-1:0]                     rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CNT_W-1:0]                     cnt, cnt_nxt, push_n, pop_n;
  logic [PUSH_PORTS-1:0][PTR_W-1:0]     widx;
  logic [POP_PORTS-1:0][PTR_W-1:0]      ridx;

  assign usage_o        = cnt;
  assign free_o         = DEPTH_C - cnt;
  assign full_o         = (cnt == DEPTH_C);
  assign empty_o        = (cnt == '0);
  assign almost_full_o  = (int'(cnt) >= AFULL_TH);
  assign almost_empty_o = (int'(cnt) <= AEMPTY_TH);

  // Each side is judged on pre-cycle state only: no credit from a same-cycle pop/push
  assign push_ack_o = (push_cnt_i != '0) && (CNT_W'(push_cnt_i) <= free_o) && !flush_i;
  assign pop_ack_o  = (pop_cnt_i != '0) && (CNT_W'(pop_cnt_i) <= cnt) && !flush_i;
  assign push_n     = push_ack_o ? CNT_W'(push_cnt_i) : '0;
  assign pop_n      = pop_ack_o ? CNT_W'(pop_cnt_i) : '0;
  assign cnt_nxt    = cnt + push_n - pop_n;

  fifo_multi_port_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_adv (
    .base(wr_ptr), .ofs((PTR_W+1)'(push_cnt_i)), .idx(wr_nxt));
  fifo_multi_port_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_adv (
    .base(rd_ptr), .ofs((PTR_W+1)'(pop_cnt_i)), .idx(rd_nxt));

  for (genvar k = 0; k < PUSH_PORTS; k++) begin : g_push
    fifo_multi_port_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_widx (
      .base(wr_ptr), .ofs((PTR_W+1)'(k)), .idx(widx[k]));
  end

  for (genvar k = 0; k < POP_PORTS; k++) begin : g_pop
    fifo_multi_port_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ridx (
      .base(rd_ptr), .ofs((PTR_W+1)'(k)), .idx(ridx[k]));
    assign data_o[k]  = mem[ridx[k]];
    assign valid_o[k] = (cnt > CNT_W'(k));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      // flush leaves mem alone; stale entries are masked by valid_o
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ack_o) begin
        for (int k = 0; k < PUSH_PORTS; k++)
          if (PSH_W'(k) < push_cnt_i) mem[widx[k]] <= data_i[k];
        wr_ptr <= wr_nxt;
      end
      if (pop_ack_o) rd_ptr <= rd_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    assert (DEPTH >= 2 && DEPTH <= 65536 && PUSH_PORTS >= 1 && POP_PORTS >= 1 &&
            DEPTH >= PUSH_PORTS && DEPTH >= POP_PORTS)
      else $error("fifo_multi_port: illegal parameters");
    if (!rst_i) begin
      assert (int'(push_cnt_i) <= PUSH_PORTS) else $error("push_cnt_i exceeds PUSH_PORTS");
      assert (int'(pop_cnt_i) <= POP_PORTS) else $error("pop_cnt_i exceeds POP_PORTS");
      assert (cnt <= DEPTH_C) else $error("occupancy exceeds DEPTH");
    end
  end
endmodule

// File: tb/tb_fifo_multi_port.sv
// Bench for fifo_multi_port: hand-derived vector table, reset/wrap sequences,
// and randomized traffic against a queue-based reference model.
module tb_fifo_multi_port;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT a: DEPTH 8
  logic             flush_a;
  logic [1:0]       push_cnt_a, pop_cnt_a;
  logic [1:0][31:0] din_a, dout_a;
  logic             push_ack_a, pop_ack_a;
  logic [1:0]       valid_a;
  logic [3:0]       usage_a, free_a;
  logic             full_a, empty_a, afull_a, aempty_a;

  // DUT b: DEPTH 5 for wrap
  logic             flush_b;
  logic [1:0]       push_cnt_b, pop_cnt_b;
  logic [1:0][31:0] din_b, dout_b;
  logic             push_ack_b, pop_ack_b;
  logic [1:0]       valid_b;
  logic [2:0]       usage_b, free_b;
  logic             full_b, empty_b, afull_b, aempty_b;

  fifo_multi_port #(.DATA_WIDTH(32), .DEPTH(8), .PUSH_PORTS(2), .POP_PORTS(2),
                    .AFULL_TH(6), .AEMPTY_TH(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a), .push_cnt_i(push_cnt_a), .data_i(din_a),
    .push_ack_o(push_ack_a), .pop_cnt_i(pop_cnt_a), .data_o(dout_a), .valid_o(valid_a),
    .pop_ack_o(pop_ack_a), .usage_o(usage_a), .free_o(free_a), .full_o(full_a),
    .empty_o(empty_a), .almost_full_o(afull_a), .almost_empty_o(aempty_a));

  fifo_multi_port #(.DATA_WIDTH(32), .DEPTH(5), .PUSH_PORTS(2), .POP_PORTS(2),
                    .AFULL_TH(4), .AEMPTY_TH(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b), .push_cnt_i(push_cnt_b), .data_i(din_b),
    .push_ack_o(push_ack_b), .pop_cnt_i(pop_cnt_b), .data_o(dout_b), .valid_o(valid_b),
    .pop_ack_o(pop_ack_b), .usage_o(usage_b), .free_o(free_b), .full_o(full_b),
    .empty_o(empty_b), .almost_full_o(afull_b), .almost_empty_o(aempty_b));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q[$];

  typedef struct {
    int psh; int d0; int d1; int pop; bit fl;
    bit e_pa; bit e_qa; int e_use; bit [1:0] m; int e_o0; int e_o1; bit e_af; bit e_ae;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(int psh, int d0, int d1, int pop, bit fl, bit pa, bit qa,
                              int use_n, bit [1:0] m, int o0, int o1, bit af, bit ae);
    vec_t v;
    v.psh = psh; v.d0 = d0; v.d1 = d1; v.pop = pop; v.fl = fl;
    v.e_pa = pa; v.e_qa = qa; v.e_use = use_n; v.m = m; v.e_o0 = o0; v.e_o1 = o1;
    v.e_af = af; v.e_ae = ae;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("usage", usage_a, n);
    chk("free", free_a, 8 - n);
    chk("full", full_a, n == 8);
    chk("empty", empty_a, n == 0);
    chk("almost_full", afull_a, n >= 6);
    chk("almost_empty", aempty_a, n <= 2);
    chk("valid", valid_a, {n > 1, n > 0});
    if (n > 0) chk("data_o0", dout_a[0], q[0]);
    if (n > 1) chk("data_o1", dout_a[1], q[1]);
  endtask

  // Drive one cycle on DUT a, check acks mid-cycle, advance model, check state after edge
  task automatic step(input int psh, input int d0, input int d1, input int pop, input bit fl,
                      output bit pa, output bit qa, output int o0, output int o1);
    int n;
    bit epa, eqa;
    push_cnt_a = 2'(psh); din_a[0] = d0; din_a[1] = d1; pop_cnt_a = 2'(pop); flush_a = fl;
    #4;
    n   = q.size();
    epa = (psh != 0) && (psh <= 8 - n) && !fl;
    eqa = (pop != 0) && (pop <= n) && !fl;
    chk("push_ack", push_ack_a, epa);
    chk("pop_ack", pop_ack_a, eqa);
    pa = push_ack_a; qa = pop_ack_a; o0 = dout_a[0]; o1 = dout_a[1];
    @(posedge clk); #1;
    if (fl) q.delete();
    else begin
      if (eqa) repeat (pop) void'(q.pop_front());
      if (epa) begin
        q.push_back(d0);
        if (psh > 1) q.push_back(d1);
      end
    end
    check_model();
  endtask

  initial begin
    bit   pa, qa;
    int   o0, o1;
    logic [31:0] got[$];
    rst = 1'b1;
    flush_a = 0; push_cnt_a = 0; pop_cnt_a = 0; din_a = '0;
    flush_b = 0; push_cnt_b = 0; pop_cnt_b = 0; din_b = '0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_usage", usage_a, 0);
    chk("rst_free", free_a, 8);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", dout_a, 0);
    chk("rst_aempty", aempty_a, 1);
    chk("rst_afull", afull_a, 0);
    chk("rst_push_ack", push_ack_a, 0);
    chk("rst_pop_ack", pop_ack_a, 0);
    rst = 1'b0;

    // fill/reject, drain order, boundary simultaneity, flush and thresholds
    tv.push_back(mk(2, 1, 2, 0, 0, 1, 0, 2, 2'b00, 0, 0, 0, 1));
    tv.push_back(mk(2, 3, 4, 0, 0, 1, 0, 4, 2'b00, 0, 0, 0, 0));
    tv.push_back(mk(2, 5, 6, 0, 0, 1, 0, 6, 2'b00, 0, 0, 1, 0));
    tv.push_back(mk(2, 7, 8, 0, 0, 1, 0, 8, 2'b00, 0, 0, 1, 0));
    tv.push_back(mk(1, 99, 0, 0, 0, 0, 0, 8, 2'b00, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 6, 2'b11, 1, 2, 1, 0));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 4, 2'b11, 3, 4, 0, 0));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 2, 2'b11, 5, 6, 0, 1));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 0, 2'b11, 7, 8, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    tv.push_back(mk(2, 10, 11, 0, 0, 1, 0, 2, 2'b00, 0, 0, 0, 1));
    tv.push_back(mk(2, 12, 13, 0, 0, 1, 0, 4, 2'b00, 0, 0, 0, 0));
    tv.push_back(mk(2, 14, 15, 0, 0, 1, 0, 6, 2'b00, 0, 0, 1, 0));
    tv.push_back(mk(1, 16, 0, 0, 0, 1, 0, 7, 2'b00, 0, 0, 1, 0));
    tv.push_back(mk(2, 17, 18, 1, 0, 0, 1, 6, 2'b11, 10, 11, 1, 0));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 4, 2'b11, 11, 12, 0, 0));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 2, 2'b11, 13, 14, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 2'b11, 15, 16, 0, 1));
    tv.push_back(mk(2, 20, 21, 2, 0, 1, 0, 3, 2'b01, 16, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 2, 0, 0, 1, 1, 2'b11, 16, 20, 0, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 2'b01, 21, 0, 0, 1));
    tv.push_back(mk(2, 30, 31, 0, 0, 1, 0, 2, 2'b00, 0, 0, 0, 1));
    tv.push_back(mk(2, 32, 33, 0, 0, 1, 0, 4, 2'b00, 0, 0, 0, 0));
    tv.push_back(mk(2, 34, 35, 0, 0, 1, 0, 6, 2'b00, 0, 0, 1, 0));
    tv.push_back(mk(2, 36, 37, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    tv.push_back(mk(2, 40, 41, 0, 0, 1, 0, 2, 2'b00, 0, 0, 0, 1));
    tv.push_back(mk(2, 42, 43, 0, 0, 1, 0, 4, 2'b11, 40, 41, 0, 0));

    foreach (tv[i]) begin
      step(tv[i].psh, tv[i].d0, tv[i].d1, tv[i].pop, tv[i].fl, pa, qa, o0, o1);
      chk($sformatf("tv%0d_push_ack", i), pa, tv[i].e_pa);
      chk($sformatf("tv%0d_pop_ack", i), qa, tv[i].e_qa);
      if (tv[i].m[0]) chk($sformatf("tv%0d_dout0", i), o0, tv[i].e_o0);
      if (tv[i].m[1]) chk($sformatf("tv%0d_dout1", i), o1, tv[i].e_o1);
      chk($sformatf("tv%0d_usage", i), usage_a, tv[i].e_use);
      chk($sformatf("tv%0d_afull", i), afull_a, tv[i].e_af);
      chk($sformatf("tv%0d_aempty", i), aempty_a, tv[i].e_ae);
    end

    // reset mid-operation with a push pending: discards contents, clears mem
    push_cnt_a = 2; din_a[0] = 32'h55; din_a[1] = 32'h66; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_usage", usage_a, 0);
    chk("midrst_free", free_a, 8);
    chk("midrst_empty", empty_a, 1);
    chk("midrst_data", dout_a, 0);
    q.delete();
    rst = 1'b0; push_cnt_a = 0;

    // DEPTH 5 wrap: stream push2/pop2 for 20 cycles, then one drain cycle
    for (int c = 0; c < 21; c++) begin
      push_cnt_b = (c < 20) ? 2'd2 : 2'd0;
      din_b[0] = 32'(2 * c); din_b[1] = 32'(2 * c + 1);
      pop_cnt_b = 2;
      #4;
      if (pop_ack_b) begin
        got.push_back(dout_b[0]);
        got.push_back(dout_b[1]);
      end
      @(posedge clk); #1;
      chk("wrap_usage_le5", usage_b > 3'd5, 0);
    end
    push_cnt_b = 0; pop_cnt_b = 0;
    chk("wrap_count", got.size(), 40);
    foreach (got[i]) chk($sformatf("wrap_seq%0d", i), got[i], i);

    // randomized traffic on DUT a against the queue model
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 2), $urandom, $urandom, $urandom_range(0, 2),
           $urandom_range(0, 24) == 0, pa, qa, o0, o1);
    end
    push_cnt_a = 0; pop_cnt_a = 0; flush_a = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
